// File: rtl/mem_req_stage.sv
// Memory request stage: issues dmem requests from the execute result and tracks outstanding responses.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned HALF/WORD accesses instead of issuing them.
package mem_req_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_NONE = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rs2_data;
        logic        mem_read;
        logic        mem_write;
        mem_size_e   mem_size;
`ifdef MEM_MISALIGN_TRAP_EN
        logic        misalign;
`endif
    } exec_state_t;

    typedef struct packed {
        logic [4:0] rd_addr;
        logic       rd_we;
    } reg_meta_t;

    typedef struct packed {
        logic stall;
        logic squash;
    } stage_ctrl_t;
endpackage

module mem_req_stage
    import mem_req_pkg::*;
#(
    parameter int unsigned OUTSTANDING_MAX = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  exec_state_t exec_state_i,
    input  reg_meta_t   reg_meta_i,
    input  stage_ctrl_t stage_ctrl_i,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    output logic        valid_o,
    output exec_state_t exec_state_o,
    output reg_meta_t   reg_meta_o,
    output logic        mem_reqwait_oa
);
    // state   | meaning
    // IDLE    | no request pending; may issue this cycle
    // REQ     | request presented, waiting for grant; fields held
    // GRANTED | granted while stalled; no re-issue until stall clears
    typedef enum logic [1:0] {IDLE, REQ, GRANTED} state_e;

    localparam int unsigned CW = $clog2(OUTSTANDING_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTANDING_MAX);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          stall, squash, mem_active, req_needed, can_issue, handshake;
    logic          cnt_inc, cnt_dec, held;
    logic [3:0]    be_c, be_q;
    logic [31:0]   wdata_c, wdata_q, addr_c, addr_q;
    logic          we_q;

    assign stall      = stage_ctrl_i.stall;
    assign squash     = stage_ctrl_i.squash;
    assign mem_active = valid_i & (exec_state_i.mem_read | exec_state_i.mem_write) & ~squash;
    assign can_issue  = cnt_q < CNT_MAX;
    assign handshake  = dmem_req_o & dmem_gnt_i;
    assign addr_c     = {exec_state_i.alu_out[31:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((exec_state_i.mem_size == MEM_HALF) & exec_state_i.alu_out[0])
                    | ((exec_state_i.mem_size == MEM_WORD) & (|exec_state_i.alu_out[1:0]));
    assign req_needed = mem_active & ~misalign;
`else
    assign req_needed = mem_active;
`endif

    always_comb begin
        be_c    = 4'b0000;
        wdata_c = exec_state_i.rs2_data;
        case (exec_state_i.mem_size)
            MEM_BYTE: begin
                be_c    = 4'b0001 << exec_state_i.alu_out[1:0];
                wdata_c = {4{exec_state_i.rs2_data[7:0]}};
            end
            MEM_HALF: begin
                be_c    = 4'b0011 << {exec_state_i.alu_out[1], 1'b0};
                wdata_c = {2{exec_state_i.rs2_data[15:0]}};
            end
            MEM_WORD: be_c = 4'b1111;
            default:  be_c = 4'b0000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dmem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req_o = req_needed & can_issue;
                if (dmem_req_o) begin
                    if (dmem_gnt_i) state_d = stall ? GRANTED : IDLE;
                    else            state_d = REQ;
                end
            end
            REQ: begin
                if (squash) begin
                    state_d = IDLE;
                end else begin
                    dmem_req_o = 1'b1;
                    if (dmem_gnt_i) state_d = stall ? GRANTED : IDLE;
                end
            end
            GRANTED: begin
                if (!stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // While waiting for a grant the bus sees the fields captured at issue time.
    assign held         = (state_q == REQ);
    assign dmem_addr_o  = held ? addr_q  : addr_c;
    assign dmem_be_o    = held ? be_q    : be_c;
    assign dmem_wdata_o = held ? wdata_q : wdata_c;
    assign dmem_we_o    = held ? we_q    : exec_state_i.mem_write;

    assign mem_reqwait_oa = req_needed & (state_q != GRANTED) & ~handshake;

    assign cnt_inc = handshake & (cnt_q != CNT_MAX);
    assign cnt_dec = dmem_rvalid_i & (cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_inc && !cnt_dec)      cnt_q <= cnt_q + 1'b1;
            else if (cnt_dec && !cnt_inc) cnt_q <= cnt_q - 1'b1;
            if (state_q == IDLE && dmem_req_o && !dmem_gnt_i) begin
                addr_q  <= addr_c;
                be_q    <= be_c;
                wdata_q <= wdata_c;
                we_q    <= exec_state_i.mem_write;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o      <= 1'b0;
            exec_state_o <= '0;
            reg_meta_o   <= '0;
        end else if (!stall) begin
            valid_o      <= valid_i & ~squash & ~mem_reqwait_oa;
            exec_state_o <= exec_state_i;
`ifdef MEM_MISALIGN_TRAP_EN
            exec_state_o.misalign <= mem_active & misalign;
`endif
            reg_meta_o   <= reg_meta_i;
        end
    end
endmodule

// File: tb/tb_mem_req_stage.sv
// Self-checking bench for mem_req_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_req_stage;
    import mem_req_pkg::*;

    localparam int MAX = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    exec_state_t exec_state_i;
    reg_meta_t   reg_meta_i;
    stage_ctrl_t stage_ctrl_i;
    logic        dmem_req_o, dmem_gnt_i, dmem_we_o, dmem_rvalid_i;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        valid_o;
    exec_state_t exec_state_o;
    reg_meta_t   reg_meta_o;
    logic        mem_reqwait_oa;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    mem_req_stage #(.OUTSTANDING_MAX(MAX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .exec_state_i(exec_state_i),
        .reg_meta_i(reg_meta_i), .stage_ctrl_i(stage_ctrl_i), .dmem_req_o(dmem_req_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_rvalid_i(dmem_rvalid_i),
        .valid_o(valid_o), .exec_state_o(exec_state_o), .reg_meta_o(reg_meta_o),
        .mem_reqwait_oa(mem_reqwait_oa)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] ref_be(input int size, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        case (size)
            0:       ref_be = 4'(1 << off);
            1:       ref_be = (off >= 2) ? 4'b1100 : 4'b0011;
            2:       ref_be = 4'b1111;
            default: ref_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] d);
        case (size)
            0:       ref_wdata = {24'd0, d[7:0]} * 32'h0101_0101;
            1:       ref_wdata = {16'd0, d[15:0]} * 32'h0001_0001;
            default: ref_wdata = d;
        endcase
    endfunction

    function automatic logic ref_misaligned(input int size, input logic [31:0] a);
        ref_misaligned = (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // kind: 0 non-memory op, 1 load, 2 store
    task automatic set_instr(input int kind, input int size, input logic [31:0] a, input logic [31:0] d);
        exec_state_i           = '0;
        exec_state_i.alu_out   = a;
        exec_state_i.rs2_data  = d;
        exec_state_i.mem_read  = (kind == 1);
        exec_state_i.mem_write = (kind == 2);
        exec_state_i.mem_size  = mem_size_e'(size[1:0]);
        reg_meta_i.rd_addr     = 5'($urandom);
        reg_meta_i.rd_we       = (kind != 2);
        valid_i                = 1'b1;
    endtask

    task automatic drain();
        valid_i = 1'b0; dmem_gnt_i = 1'b0; stage_ctrl_i = '0;
        dmem_rvalid_i = 1'b1;
        repeat (MAX + 1) step();
        dmem_rvalid_i = 1'b0;
        model_cnt = 0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b0; exec_state_i = '0; reg_meta_i = '0; stage_ctrl_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", dmem_req_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
        checks++; if (exec_state_o !== exec_state_t'('0) || reg_meta_o !== reg_meta_t'('0)) begin
            errors++; $display("FAIL reset_regs: exec %h meta %h exp 0", exec_state_o, reg_meta_o); end
        checks++; if (mem_reqwait_oa !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b exp 0", mem_reqwait_oa); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_store_byte();
        drain();
        set_instr(2, 0, 32'h0000_0103, 32'hA1B2_C3D4);
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL sb_req: got %b exp 1", dmem_req_o); end
        checks++; if (dmem_be_o !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b exp 1000", dmem_be_o); end
        checks++; if (dmem_wdata_o !== 32'hD4D4_D4D4) begin errors++; $display("FAIL sb_wdata: got %h exp d4d4d4d4", dmem_wdata_o); end
        checks++; if (dmem_addr_o !== 32'h0000_0100 || dmem_we_o !== 1'b1) begin
            errors++; $display("FAIL sb_addr: got %h we %b exp 00000100 we 1", dmem_addr_o, dmem_we_o); end
        checks++; if (mem_reqwait_oa !== 1'b0) begin errors++; $display("FAIL sb_wait: got %b exp 0", mem_reqwait_oa); end
        step();
        valid_i = 1'b0; dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1 || exec_state_o.rs2_data !== 32'hA1B2_C3D4) begin
            errors++; $display("FAIL sb_valid_o: got %b data %h exp 1 a1b2c3d4", valid_o, exec_state_o.rs2_data); end
        step();
    endtask

    task automatic test_load_delayed();
        drain();
        set_instr(1, 2, 32'h0000_0200, 32'h0);
        for (int c = 0; c < 4; c++) begin
            dmem_gnt_i = (c == 3);
            @(negedge clk_i);
            checks++; if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h200 || dmem_we_o !== 1'b0 || dmem_be_o !== 4'hF) begin
                errors++; $display("FAIL lw_req c%0d: req %b addr %h we %b be %b exp 1 200 0 1111", c, dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o); end
            checks++; if (mem_reqwait_oa !== (c < 3)) begin
                errors++; $display("FAIL lw_wait c%0d: got %b exp %b", c, mem_reqwait_oa, (c < 3)); end
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lw_bubble c%0d: got %b exp 0", c, valid_o); end
            step();
        end
        valid_i = 1'b0; dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1 || exec_state_o.alu_out !== 32'h200) begin
            errors++; $display("FAIL lw_valid_o: got %b addr %h exp 1 200", valid_o, exec_state_o.alu_out); end
        checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL lw_after: got %b exp 0", dmem_req_o); end
        step();
    endtask

    task automatic test_outstanding();
        drain();
        for (int i = 0; i < MAX; i++) begin
            set_instr(1, 2, 32'h1000 + 32'(i * 4), 32'h0);
            dmem_gnt_i = 1'b1;
            @(negedge clk_i);
            checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL os_issue%0d: got %b exp 1", i, dmem_req_o); end
            step();
        end
        set_instr(1, 2, 32'h2000, 32'h0);
        dmem_gnt_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            dmem_rvalid_i = (c == 1);
            @(negedge clk_i);
            checks++; if (dmem_req_o !== (c == 2)) begin
                errors++; $display("FAIL os_full c%0d: req %b exp %b", c, dmem_req_o, (c == 2)); end
            checks++; if (mem_reqwait_oa !== (c != 2)) begin
                errors++; $display("FAIL os_wait c%0d: got %b exp %b", c, mem_reqwait_oa, (c != 2)); end
            step();
        end
        dmem_rvalid_i = 1'b0;
        drain();
    endtask

    task automatic test_stall_granted();
        drain();
        set_instr(1, 2, 32'h0000_0300, 32'h0);
        dmem_gnt_i = 1'b1;
        stage_ctrl_i.stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            stage_ctrl_i.stall = (c < 2);
            @(negedge clk_i);
            checks++; if (dmem_req_o !== (c == 0)) begin
                errors++; $display("FAIL st_req c%0d: got %b exp %b", c, dmem_req_o, (c == 0)); end
            checks++; if (mem_reqwait_oa !== 1'b0 || valid_o !== 1'b0) begin
                errors++; $display("FAIL st_hold c%0d: wait %b valid_o %b exp 0 0", c, mem_reqwait_oa, valid_o); end
            step();
        end
        valid_i = 1'b0; dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL st_valid_o: got %b exp 1", valid_o); end
        step();
        for (int i = 0; i < MAX; i++) begin
            set_instr(1, 2, 32'h3000, 32'h0);
            dmem_gnt_i = 1'b1;
            @(negedge clk_i);
            checks++; if (dmem_req_o !== (i < MAX - 1)) begin
                errors++; $display("FAIL st_count%0d: req %b exp %b", i, dmem_req_o, (i < MAX - 1)); end
            step();
        end
        drain();
    endtask

    task automatic test_squash();
        drain();
        set_instr(1, 2, 32'h0000_0400, 32'h0);
        @(negedge clk_i);
        checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL sq_req: got %b exp 1", dmem_req_o); end
        step();
        stage_ctrl_i.squash = 1'b1;
        @(negedge clk_i);
        checks++; if (dmem_req_o !== 1'b0 || mem_reqwait_oa !== 1'b0) begin
            errors++; $display("FAIL sq_withdraw: req %b wait %b exp 0 0", dmem_req_o, mem_reqwait_oa); end
        step();
        stage_ctrl_i.squash = 1'b0; valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (dmem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL sq_after: req %b valid_o %b exp 0 0", dmem_req_o, valid_o); end
        step();
    endtask

    task automatic test_misalign();
        drain();
        set_instr(2, 1, 32'h0000_0101, 32'h0000_BEEF);
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (dmem_req_o !== 1'b0 || mem_reqwait_oa !== 1'b0) begin
            errors++; $display("FAIL mis_req: req %b wait %b exp 0 0", dmem_req_o, mem_reqwait_oa); end
        step();
        valid_i = 1'b0; dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b1 || exec_state_o.misalign !== 1'b1) begin
            errors++; $display("FAIL mis_trap: valid_o %b misalign %b exp 1 1", valid_o, exec_state_o.misalign); end
`else
        checks++; if (dmem_req_o !== 1'b1 || dmem_be_o !== 4'b0011 || dmem_addr_o !== 32'h100) begin
            errors++; $display("FAIL mis_issue: req %b be %b addr %h exp 1 0011 100", dmem_req_o, dmem_be_o, dmem_addr_o); end
        checks++; if (dmem_wdata_o !== 32'hBEEF_BEEF) begin
            errors++; $display("FAIL mis_wdata: got %h exp beefbeef", dmem_wdata_o); end
        step();
        valid_i = 1'b0; dmem_gnt_i = 1'b0;
`endif
        step();
    endtask

    task automatic test_reset_in_req();
        drain();
        for (int i = 0; i < MAX; i++) begin
            set_instr(1, 2, 32'h5000, 32'h0);
            dmem_gnt_i = (i < MAX - 1);
            step();
        end
        @(negedge clk_i);
        checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL rr_in_req: got %b exp 1", dmem_req_o); end
        #2;
        rst_ni = 1'b0; valid_i = 1'b0; dmem_gnt_i = 1'b0;
        #1;
        checks++; if (dmem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL rr_async: req %b valid_o %b exp 0 0", dmem_req_o, valid_o); end
        checks++; if (exec_state_o !== exec_state_t'('0) || reg_meta_o !== reg_meta_t'('0)) begin
            errors++; $display("FAIL rr_regs: exec %h meta %h exp 0", exec_state_o, reg_meta_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        dmem_rvalid_i = 1'b1;
        repeat (2) step();
        dmem_rvalid_i = 1'b0;
        for (int i = 0; i <= MAX; i++) begin
            set_instr(1, 2, 32'h6000, 32'h0);
            dmem_gnt_i = 1'b1;
            @(negedge clk_i);
            checks++; if (dmem_req_o !== (i < MAX)) begin
                errors++; $display("FAIL rr_count%0d: req %b exp %b", i, dmem_req_o, (i < MAX)); end
            step();
        end
        drain();
    endtask

    task automatic test_random();
        int kind, size, delay, waited, cyc, next_cnt;
        logic [31:0] a, d;
        logic exp_req, exp_wait, exp_valid_o, rv, done, mis;
        exec_state_t exp_es;
        reg_meta_t exp_meta;
        drain();
        exp_valid_o = 1'b0; exp_es = '0; exp_meta = '0;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2); size = $urandom_range(0, 3);
            a = $urandom; d = $urandom; delay = $urandom_range(0, 3);
            set_instr(kind, size, a, d);
            mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis = (kind != 0) && ref_misaligned(size, a);
`endif
            waited = 0; done = 1'b0; cyc = 0;
            while (!done && cyc < 40) begin
                exp_req = (kind != 0) && !mis && (waited > 0 || model_cnt < MAX);
                dmem_gnt_i = exp_req && (waited >= delay);
                rv = ($urandom_range(0, 2) == 0);
                dmem_rvalid_i = rv;
                exp_wait = (kind != 0) && !mis && !(exp_req && dmem_gnt_i);
                @(negedge clk_i);
                checks++; if (dmem_req_o !== exp_req) begin
                    errors++; $display("FAIL rnd_req n%0d: got %b exp %b", n, dmem_req_o, exp_req); end
                if (exp_req) begin
                    checks++; if (dmem_addr_o !== (a - (a % 4)) || dmem_we_o !== (kind == 2) || dmem_be_o !== ref_be(size, a)) begin
                        errors++; $display("FAIL rnd_fields n%0d: addr %h we %b be %b exp %h %b %b", n,
                            dmem_addr_o, dmem_we_o, dmem_be_o, a - (a % 4), (kind == 2), ref_be(size, a)); end
                    if (kind == 2 && size < 3) begin
                        checks++; if (dmem_wdata_o !== ref_wdata(size, d)) begin
                            errors++; $display("FAIL rnd_wdata n%0d: got %h exp %h", n, dmem_wdata_o, ref_wdata(size, d)); end
                    end
                end
                checks++; if (mem_reqwait_oa !== exp_wait) begin
                    errors++; $display("FAIL rnd_wait n%0d: got %b exp %b", n, mem_reqwait_oa, exp_wait); end
                checks++; if (valid_o !== exp_valid_o || (exp_valid_o && (exec_state_o !== exp_es || reg_meta_o !== exp_meta))) begin
                    errors++; $display("FAIL rnd_pipe n%0d: valid_o %b exec %h meta %h exp %b %h %h", n,
                        valid_o, exec_state_o, reg_meta_o, exp_valid_o, exp_es, exp_meta); end
                next_cnt = model_cnt;
                if (exp_req && dmem_gnt_i) next_cnt++;
                if (rv && model_cnt > 0) next_cnt--;
                model_cnt = next_cnt;
                exp_valid_o = !exp_wait;
                exp_es = exec_state_i;
`ifdef MEM_MISALIGN_TRAP_EN
                exp_es.misalign = mis;
`endif
                exp_meta = reg_meta_i;
                if (exp_req) waited++;
                if (!exp_wait) done = 1'b1;
                cyc++;
                step();
            end
            if (!done) begin
                checks++; errors++;
                $display("FAIL rnd_timeout n%0d: no completion after %0d cycles, exp completion", n, cyc);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_delayed();
        test_outstanding();
        test_stall_granted();
        test_squash();
        test_misalign();
        test_reset_in_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
